// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing with memory
// handshake waits, datapath strobes/selects, and a retired-instruction counter.
module multicycle_controller #(
  parameter int FUNCT_W  = 6,
  parameter int IMM_BIT  = 5,
  parameter int LOAD_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               pc_w,
  output logic               ir_w,
  output logic               reg_w,
  output logic               mem_w,
  output logic               branch,
  output logic               alu_op,
  output logic               adr_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [1:0]         reg_src,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_pc_w, w_ir_w, w_reg_w, w_mem_w, w_branch, w_alu_op, w_adr_src;
  logic [1:0]       w_alu_src_a, w_alu_src_b, w_result_src, w_reg_src;
  logic             w_done, w_illegal;
  logic             w_unused_funct;

  assign w_unused_funct = ^funct;

  always_comb begin
    w_next       = S_FETCH;
    w_pc_w       = 1'b0;
    w_ir_w       = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 1'b0;
    w_adr_src    = 1'b0;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_result_src = 2'b00;
    w_reg_src    = 2'b00;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_pc_w       = mem_ready;
        w_ir_w       = mem_ready;
        w_next       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b10;
        case (op)
          2'b00:   w_next = funct[IMM_BIT] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_next      = funct[LOAD_BIT] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        w_next    = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_w      = 1'b1;
        w_done       = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src = 1'b1;
        w_reg_src = 2'b10;
        w_mem_w   = 1'b1;
        w_done    = mem_ready;
        w_next    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR, S_EXECI: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_alu_op    = 1'b1;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_w = 1'b1;
        w_done  = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_reg_src   = 2'b01;
        w_branch    = 1'b1;
        w_done      = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_done) r_retired <= r_retired + 1'b1;
    end
  end

  // Everything the datapath acts on is held off while reset is asserted.
  assign pc_w       = w_pc_w       & ~rst;
  assign ir_w       = w_ir_w       & ~rst;
  assign reg_w      = w_reg_w      & ~rst;
  assign mem_w      = w_mem_w      & ~rst;
  assign branch     = w_branch     & ~rst;
  assign alu_op     = w_alu_op     & ~rst;
  assign adr_src    = w_adr_src    & ~rst;
  assign alu_src_a  = rst ? 2'b00 : w_alu_src_a;
  assign alu_src_b  = rst ? 2'b00 : w_alu_src_b;
  assign result_src = rst ? 2'b00 : w_result_src;
  assign reg_src    = rst ? 2'b00 : w_reg_src;
  assign instr_done = w_done       & ~rst;
  assign illegal    = w_illegal    & ~rst;
  assign state      = r_state;
  assign retired    = r_retired;

endmodule
